memory_arbiter: RTL and testbench
=================================

MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001: Parameter TIMEOUT, default 16, is the maximum number of cycles a granted access waits for ramready before it is aborted.
REQ-002: CLK  input  1  rising-edge clock; all state updates on posedge CLK.
REQ-003: nRST  input  1  reset, synchronous, active-low; sampled only on posedge CLK.
REQ-004: iREN  input  1  instruction fetch request.
REQ-005: iaddr  input  32  instruction fetch address.
REQ-006: iload  output  32  instruction fetch data.
REQ-007: ihit  output  1  instruction access complete, one-cycle pulse.
REQ-008: dREN, dWEN  input  1 each  data read and data write requests.
REQ-009: daddr, dstore  input  32 each  data address and data store value.
REQ-010: dload  output  32  data read return.
REQ-011: dhit  output  1  data access complete, one-cycle pulse.
REQ-012: ramREN, ramWEN  output  1 each  RAM read and RAM write strobes.
REQ-013: ramaddr, ramstore  output  32 each  RAM address and RAM write data.
REQ-014: ramload  input  32  RAM read data.
REQ-015: ramready  input  1  RAM access completes this cycle.
REQ-016: busy  output  1  high in any state other than IDLE.
REQ-017: err  output  1  sticky timeout flag.

Function
REQ-018: The FSM SHALL have four states, registered: IDLE, IFETCH, DREAD, DWRITE.
REQ-019: In IDLE, the FSM SHALL take the next state from the requests sampled that cycle: dWEN goes to DWRITE; else dREN goes to DREAD; else iREN goes to IFETCH; else it stays in IDLE.
REQ-020: Fairness override: if the last completed grant was data (flag last_d=1) and iREN=1 in IDLE, the FSM SHALL go to IFETCH regardless of data requests.
REQ-021: last_d SHALL be set on dhit and cleared on ihit.
REQ-022: RAM strobes SHALL be combinational from state only: IFETCH gives ramREN=1 and ramaddr=iaddr; DREAD gives ramREN=1 and ramaddr=daddr; DWRITE gives ramWEN=1, ramaddr=daddr and ramstore=dstore; IDLE drives all RAM outputs to 0.
REQ-023: Latency: a request accepted in IDLE at cycle N SHALL drive RAM strobes from cycle N+1.
REQ-024: On ramready=1 in IFETCH, ihit SHALL be 1 and iload=ramload in the same cycle, and the next state SHALL be IDLE.
REQ-025: On ramready=1 in DREAD or DWRITE, dhit SHALL be 1 in the same cycle, with dload=ramload for DREAD only, and the next state SHALL be IDLE.
REQ-026: iload and dload SHALL be 0 when the matching hit is 0.
REQ-027: Every access SHALL spend at least one IDLE cycle after completion; back-to-back accesses are therefore 2 or more cycles apart.
REQ-028: Abort: if the requester deasserts its granted request while in a non-IDLE state, the FSM SHALL return to IDLE next cycle with no hit generated.
REQ-029: For DWRITE, "its granted request" is dWEN; for DREAD it is dREN; for IFETCH it is iREN.
REQ-030: ramready=1 in IDLE SHALL be ignored.
REQ-031: ihit and dhit SHALL never both be 1 in the same cycle.
REQ-032: Requesters hold address and data stable until their hit; the block performs no latching of them.

Reset
REQ-033: With nRST=0 at posedge CLK, the block SHALL set state=IDLE, last_d=0, timeout counter=0 and err=0, including when reset arrives mid-access.
REQ-034: During and after reset, all outputs SHALL be 0 until a new grant.

Configuration
REQ-035: With MEMARB_TIMEOUT_EN defined, a counter SHALL clear on entry to a non-IDLE state and increment each cycle without ramready.
REQ-036: With MEMARB_TIMEOUT_EN defined, when the counter reaches TIMEOUT the FSM SHALL return to IDLE with no hit, and err SHALL set and stay set until reset.
REQ-037: With MEMARB_TIMEOUT_EN undefined, there SHALL be no counter, err SHALL be tied to 0, and the FSM SHALL wait indefinitely for ramready.

Verification
REQ-038: Instruction read: iREN=1, iaddr=0x40, ramready high 2 cycles later with ramload=0x8C010004 -> ramREN=1 and ramaddr=0x40 from cycle N+1, then an ihit pulse with iload=0x8C010004, then IDLE.
REQ-039: Data priority: dREN=1 and iREN=1 together in IDLE with last_d=0 -> DREAD is granted first; after dhit, IFETCH is granted next even though dREN is still held.
REQ-040: Write over read: dREN=1 and dWEN=1 with daddr=0x100 and dstore=0xDEADBEEF -> ramWEN=1, ramstore=0xDEADBEEF, ramREN=0, then a dhit pulse.
REQ-041: Abort: grant IFETCH, drop iREN before ramready -> IDLE next cycle, ihit stays 0, RAM strobes go to 0.
REQ-042: Reset mid-access: nRST=0 while in DWRITE -> IDLE after that posedge, ramWEN=0, busy=0, err=0.
REQ-043: Timeout (MEMARB_TIMEOUT_EN defined, TIMEOUT=16): hold ramready=0 -> abort after 16 cycles, err=1 and sticky, no hit; without the macro -> still waiting after 100 cycles with err=0.

Source files
------------

// File: rtl/memory_arbiter.sv
// Single-port RAM arbiter between an instruction fetch port and a data port.
// Optional access timeout with sticky err is enabled by defining MEMARB_TIMEOUT_EN.
module memory_arbiter #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        CLK,
  input  logic        nRST,
  input  logic        iREN,
  input  logic [31:0] iaddr,
  output logic [31:0] iload,
  output logic        ihit,
  input  logic        dREN,
  input  logic        dWEN,
  input  logic [31:0] daddr,
  input  logic [31:0] dstore,
  output logic [31:0] dload,
  output logic        dhit,
  output logic        ramREN,
  output logic        ramWEN,
  output logic [31:0] ramaddr,
  output logic [31:0] ramstore,
  input  logic [31:0] ramload,
  input  logic        ramready,
  output logic        busy,
  output logic        err
);

  typedef enum logic [1:0] {IDLE, IFETCH, DREAD, DWRITE} state_t;

  state_t r_state;
  state_t w_next;
  logic   r_last_d;
  logic   w_held;
  logic   w_expire;

`ifdef MEMARB_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_cnt;
  logic          r_err;

  // Expiry counts only while the requester still wants the access; a dropped
  // request is a requester abort, not a timeout.
  assign w_expire = (r_state != IDLE) && w_held && !ramready &&
                    (r_cnt == CW'(TIMEOUT - 1));
  assign err      = r_err;

  always_ff @(posedge CLK) begin
    if (!nRST || r_state == IDLE) begin
      r_cnt <= '0;
    end else if (!ramready) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_err <= 1'b0;
    end else if (w_expire) begin
      r_err <= 1'b1;
    end
  end
`else
  assign w_expire = 1'b0;
  assign err      = 1'b0;
`endif

  always_comb begin
    w_held = 1'b0;
    case (r_state)
      IFETCH:  w_held = iREN;
      DREAD:   w_held = dREN;
      DWRITE:  w_held = dWEN;
      default: w_held = 1'b0;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      r_last_d <= 1'b0;
    end else if (dhit) begin
      r_last_d <= 1'b1;
    end else if (ihit) begin
      r_last_d <= 1'b0;
    end
  end

  always_comb begin
    w_next   = r_state;
    ramREN   = 1'b0;
    ramWEN   = 1'b0;
    ramaddr  = '0;
    ramstore = '0;
    ihit     = 1'b0;
    dhit     = 1'b0;
    iload    = '0;
    dload    = '0;
    busy     = (r_state != IDLE);

    case (r_state)
      IDLE: begin
        if (iREN && r_last_d) begin
          w_next = IFETCH;
        end else if (dWEN) begin
          w_next = DWRITE;
        end else if (dREN) begin
          w_next = DREAD;
        end else if (iREN) begin
          w_next = IFETCH;
        end
      end
      IFETCH: begin
        ramREN  = 1'b1;
        ramaddr = iaddr;
      end
      DREAD: begin
        ramREN  = 1'b1;
        ramaddr = daddr;
      end
      DWRITE: begin
        ramWEN   = 1'b1;
        ramaddr  = daddr;
        ramstore = dstore;
      end
      default: w_next = IDLE;
    endcase

    if (r_state != IDLE) begin
      if (w_held && ramready) begin
        w_next = IDLE;
        if (r_state == IFETCH) begin
          ihit  = 1'b1;
          iload = ramload;
        end else begin
          dhit = 1'b1;
          if (r_state == DREAD) begin
            dload = ramload;
          end
        end
      end else if (!w_held || w_expire) begin
        w_next = IDLE;
      end
    end
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Self-checking bench for memory_arbiter: directed scenarios plus randomized
// traffic, all compared against a transaction-level reference model.
module tb_memory_arbiter;

  localparam int unsigned TO = 16;

  logic        CLK = 1'b0;
  logic        nRST;
  logic        iREN, dREN, dWEN, ramready;
  logic [31:0] iaddr, daddr, dstore, ramload;
  logic [31:0] iload, dload, ramaddr, ramstore;
  logic        ihit, dhit, ramREN, ramWEN, busy, err;

  memory_arbiter #(.TIMEOUT(TO)) dut (
    .CLK(CLK), .nRST(nRST),
    .iREN(iREN), .iaddr(iaddr), .iload(iload), .ihit(ihit),
    .dREN(dREN), .dWEN(dWEN), .daddr(daddr), .dstore(dstore),
    .dload(dload), .dhit(dhit),
    .ramREN(ramREN), .ramWEN(ramWEN), .ramaddr(ramaddr), .ramstore(ramstore),
    .ramload(ramload), .ramready(ramready), .busy(busy), .err(err)
  );

  always #5 CLK = ~CLK;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  // Reference model: which requester currently owns the RAM, how long it has
  // waited, fairness history and the sticky timeout flag.
  localparam int OWN_NONE = 0, OWN_I = 1, OWN_DR = 2, OWN_DW = 3;
  int          m_owner;
  int unsigned m_wait;
  bit          m_data_last;
  bit          m_err;

  function automatic bit owner_wants();
    return (m_owner == OWN_I  && iREN) ||
           (m_owner == OWN_DR && dREN) ||
           (m_owner == OWN_DW && dWEN);
  endfunction

  task automatic compare_all();
    bit          fin;
    logic [31:0] e_addr;
    fin    = (m_owner != OWN_NONE) && owner_wants() && ramready;
    e_addr = (m_owner == OWN_I) ? iaddr : (m_owner == OWN_NONE) ? 32'h0 : daddr;
    check("busy",     32'(busy),   32'(m_owner != OWN_NONE));
    check("ramREN",   32'(ramREN), 32'(m_owner == OWN_I || m_owner == OWN_DR));
    check("ramWEN",   32'(ramWEN), 32'(m_owner == OWN_DW));
    check("ramaddr",  ramaddr,     e_addr);
    check("ramstore", ramstore,    (m_owner == OWN_DW) ? dstore : 32'h0);
    check("ihit",     32'(ihit),   32'(fin && m_owner == OWN_I));
    check("iload",    iload,       (fin && m_owner == OWN_I) ? ramload : 32'h0);
    check("dhit",     32'(dhit),   32'(fin && m_owner != OWN_I));
    check("dload",    dload,       (fin && m_owner == OWN_DR) ? ramload : 32'h0);
    check("err",      32'(err),    32'(m_err));
  endtask

  task automatic model_advance();
    bit timeout_on;
`ifdef MEMARB_TIMEOUT_EN
    timeout_on = 1'b1;
`else
    timeout_on = 1'b0;
`endif
    if (!nRST) begin
      m_owner = OWN_NONE; m_wait = 0; m_data_last = 0; m_err = 0;
    end else if (m_owner == OWN_NONE) begin
      m_wait = 0;
      if (iREN && (m_data_last || !(dREN || dWEN))) m_owner = OWN_I;
      else if (dWEN)                                m_owner = OWN_DW;
      else if (dREN)                                m_owner = OWN_DR;
    end else if (owner_wants() && ramready) begin
      m_data_last = (m_owner != OWN_I);
      m_owner     = OWN_NONE;
    end else if (!owner_wants()) begin
      m_owner = OWN_NONE;
    end else if (timeout_on && m_wait + 1 == TO) begin
      m_owner = OWN_NONE;
      m_err   = 1'b1;
    end else begin
      m_wait++;
    end
  endtask

  // Inputs are applied 1 time unit after a rising edge; outputs are
  // sampled 3 units later, well clear of either edge.
  task automatic settle();
    #3;
  endtask

  task automatic finish_cycle();
    compare_all();
    model_advance();
    @(posedge CLK);
    #1;
  endtask

  task automatic cycle();
    settle();
    finish_cycle();
  endtask

  task automatic drive(input logic i, input logic dr, input logic dw, input logic rr);
    iREN = i; dREN = dr; dWEN = dw; ramready = rr;
  endtask

  initial begin
    nRST = 1'b0;
    drive(0, 0, 0, 0);
    iaddr = '0; daddr = '0; dstore = '0; ramload = '0;
    m_owner = OWN_NONE; m_wait = 0; m_data_last = 0; m_err = 0;
    @(posedge CLK); #1;
    cycle(); cycle();
    check("rst_busy", 32'(busy), 32'h0);
    nRST = 1'b1;

    // Instruction read with ramready two cycles after acceptance.
    iaddr = 32'h40; ramload = 32'h8C010004;
    drive(1, 0, 0, 0); cycle();
    settle();
    check("if_ramaddr", ramaddr, 32'h40);
    check("if_ramREN", 32'(ramREN), 32'h1);
    finish_cycle();
    drive(1, 0, 0, 1); settle();
    check("if_ihit", 32'(ihit), 32'h1);
    check("if_iload", iload, 32'h8C010004);
    finish_cycle();
    drive(0, 0, 0, 0); settle();
    check("if_idle", 32'(busy), 32'h0);
    finish_cycle();

    // Data wins first, then fairness hands the next grant to fetch.
    iaddr = 32'h200; daddr = 32'h300; ramload = 32'h1234_5678;
    drive(1, 1, 0, 0); cycle();
    drive(1, 1, 0, 1); settle();
    check("pri_dhit", 32'(dhit), 32'h1);
    check("pri_dload", dload, 32'h1234_5678);
    finish_cycle();
    drive(1, 1, 0, 0); cycle();
    settle();
    check("fair_ramaddr", ramaddr, 32'h200);
    finish_cycle();
    drive(1, 1, 0, 1); cycle();
    drive(0, 0, 0, 0); cycle();

    // Write beats read.
    daddr = 32'h100; dstore = 32'hDEADBEEF;
    drive(0, 1, 1, 0); cycle();
    settle();
    check("wr_ramWEN", 32'(ramWEN), 32'h1);
    check("wr_ramREN", 32'(ramREN), 32'h0);
    check("wr_ramstore", ramstore, 32'hDEADBEEF);
    finish_cycle();
    drive(0, 1, 1, 1); settle();
    check("wr_dhit", 32'(dhit), 32'h1);
    check("wr_dload", dload, 32'h0);
    finish_cycle();
    drive(0, 0, 0, 0); cycle();

    // Fetch abort by dropping iREN.
    drive(1, 0, 0, 0); cycle(); cycle();
    drive(0, 0, 0, 1); settle();
    check("abort_ihit", 32'(ihit), 32'h0);
    finish_cycle();
    settle();
    check("abort_ramREN", 32'(ramREN), 32'h0);
    check("abort_busy", 32'(busy), 32'h0);
    finish_cycle();

    // Reset in the middle of a write.
    drive(0, 0, 1, 0); cycle(); cycle();
    nRST = 1'b0; cycle();
    settle();
    check("rstmid_ramWEN", 32'(ramWEN), 32'h0);
    check("rstmid_busy", 32'(busy), 32'h0);
    check("rstmid_err", 32'(err), 32'h0);
    finish_cycle();
    nRST = 1'b1; drive(0, 0, 0, 0); cycle();

    // RAM never answers.
    drive(0, 1, 0, 0);
    for (int unsigned k = 0; k < 101; k++) cycle();
    settle();
`ifdef MEMARB_TIMEOUT_EN
    check("to_err", 32'(err), 32'h1);
`else
    check("to_busy", 32'(busy), 32'h1);
    check("to_err", 32'(err), 32'h0);
`endif
    finish_cycle();
    drive(0, 0, 0, 0); nRST = 1'b0; cycle(); nRST = 1'b1; cycle();

    // Randomized traffic with mostly-held requests and occasional resets.
    for (int unsigned k = 0; k < 3000; k++) begin
      if ($urandom_range(7) == 0) iREN = ~iREN;
      if ($urandom_range(7) == 0) dREN = ~dREN;
      if ($urandom_range(9) == 0) dWEN = ~dWEN;
      ramready = ($urandom_range(2) == 0);
      if ($urandom_range(15) == 0) ramready = 1'b0;
      iaddr   = $urandom;
      daddr   = $urandom;
      dstore  = $urandom;
      ramload = $urandom;
      nRST    = ($urandom_range(127) != 0);
      cycle();
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
